correlation_pipe: RTL and testbench

- Parametrised successor to the fixed three-tap systolic correlator.
- Transposed-form chain of TAPS processing elements computing a sliding weighted sum over an 8-bit-style sample stream.
- Adds runtime-writable coefficients, a correlation/convolution mode, a sample-valid handshake with stall, flush, output-valid and asynchronous reset.
- Sits between the sample source and downstream peak/threshold logic.

---
 rtl/correlation_pipe.sv | 113 +++++++++++
 tb/tb_correlation_pipe.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/correlation_pipe.sv
// correlation_pipe: transposed-form systolic correlator with TAPS PEs,
// runtime coefficients, corr/conv mode, stall, flush and priming flag.
module correlation_pipe #(
   parameter int TAPS   = 3,
   parameter int DATA_W = 8,
   parameter int COEF_W = 8,
   parameter int ACC_W  = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DATA_W-1:0]       x,
   input  logic                    x_valid,
   input  logic                    flush,
   input  logic                    mode_conv,
   input  logic                    coef_we,
   input  logic [$clog2(TAPS)-1:0] coef_addr,
   input  logic [COEF_W-1:0]       coef_data,
   output logic [ACC_W-1:0]        y,
   output logic                    y_valid
);

   localparam int AW = $clog2(TAPS);
   localparam int PW = DATA_W + COEF_W;
   localparam int CW = $clog2(TAPS + 1);

   logic [COEF_W-1:0] r_coef [TAPS];
   logic [COEF_W-1:0] w_wt   [TAPS];
   logic [PW-1:0]     w_full [TAPS];
   logic [ACC_W-1:0]  w_prod [TAPS];
   logic [ACC_W-1:0]  r_p    [TAPS];

   logic [CW-1:0] r_cnt;
   logic [CW-1:0] w_cnt_nxt;
   logic          r_yv;
   logic          w_accept;
   logic          w_addr_ok;
   logic          w_full_cnt;

   // flush wins over a sample on the same edge
   assign w_accept = x_valid & ~flush;

   assign w_addr_ok =
      ({1'b0, coef_addr} < (AW + 1)'(TAPS));

   assign w_full_cnt = (r_cnt == CW'(TAPS));

   assign w_cnt_nxt = w_full_cnt ? r_cnt
                                 : r_cnt + 1'b1;

   // per-PE weight select and product, truncated to the accumulator
   for (genvar k = 0; k < TAPS; k++) begin : g_pe_mul
      assign w_wt[k] = mode_conv ? r_coef[TAPS-1-k]
                                 : r_coef[k];
      assign w_full[k] = PW'(x) * PW'(w_wt[k]);
      assign w_prod[k] = ACC_W'(w_full[k]);
   end

   // coefficient bank: defaults k+2, writable in any cycle
   for (genvar k = 0; k < TAPS; k++) begin : g_coef
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_coef[k] <= COEF_W'(k + 2);
         end else if (coef_we && w_addr_ok &&
                      (coef_addr == AW'(k))) begin
            r_coef[k] <= coef_data;
         end
      end
   end

   // first PE: starts a new partial sum from the product alone
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_p[0] <= '0;
      end else if (flush) begin
         r_p[0] <= '0;
      end else if (x_valid) begin
         r_p[0] <= w_prod[0];
      end
   end

   // remaining PEs: add own product to upstream partial sum
   for (genvar k = 1; k < TAPS; k++) begin : g_pe_acc
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            r_p[k] <= '0;
         end else if (flush) begin
            r_p[k] <= '0;
         end else if (x_valid) begin
            r_p[k] <= r_p[k-1] + w_prod[k];
         end
      end
   end

   // priming counter and registered output-valid pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
         r_yv  <= 1'b0;
      end else if (flush) begin
         r_cnt <= '0;
         r_yv  <= 1'b0;
      end else if (w_accept) begin
         r_cnt <= w_cnt_nxt;
         r_yv  <= (w_cnt_nxt == CW'(TAPS));
      end else begin
         r_yv  <= 1'b0;
      end
   end

   assign y       = r_p[TAPS-1];
   assign y_valid = r_yv;

endmodule

// File: tb/tb_correlation_pipe.sv
// tb_correlation_pipe: scoreboard bench; a history-based model pushes
// the expected y/y_valid per cycle, popped after each rising edge.
module tb_correlation_pipe;

   localparam int T = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] x = '0;
   logic       x_valid = 1'b0;
   logic       flush = 1'b0;
   logic       mode_conv = 1'b0;
   logic       coef_we = 1'b0;
   logic [1:0] coef_addr = '0;
   logic [7:0] coef_data = '0;
   logic [15:0] y;
   logic       y_valid;

   int checks = 0;
   int errors = 0;

   logic [16:0] sb_q [$];

   int mc [T];
   int hx [T];
   int hw [T][T];
   int mcnt;

   correlation_pipe #(
      .TAPS(T), .DATA_W(8), .COEF_W(8), .ACC_W(16)
   ) dut (
      .clk(clk), .rst(rst), .x(x), .x_valid(x_valid),
      .flush(flush), .mode_conv(mode_conv),
      .coef_we(coef_we), .coef_addr(coef_addr),
      .coef_data(coef_data), .y(y), .y_valid(y_valid)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d want %0d", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < T; k++) begin
         mc[k] = k + 2;
         hx[k] = 0;
         for (int j = 0; j < T; j++) hw[k][j] = 0;
      end
      mcnt = 0;
   endtask

   // age j sample used weight index T-1-j when it was accepted
   function automatic logic [15:0] model_y();
      int s = 0;
      for (int j = 0; j < T; j++)
         s += (hw[j][T-1-j] * hx[j]) & 16'hffff;
      return 16'(s);
   endfunction

   task automatic step(input logic       v,
                       input logic [7:0] xi,
                       input logic       fl,
                       input logic       cv,
                       input logic       we,
                       input logic [1:0] a,
                       input logic [7:0] d,
                       input string      tag);
      logic ev;
      logic [16:0] e;
      @(negedge clk);
      x_valid = v; x = xi; flush = fl;
      mode_conv = cv; coef_we = we;
      coef_addr = a; coef_data = d;
      ev = 1'b0;
      if (fl) begin
         for (int j = 0; j < T; j++) begin
            hx[j] = 0;
            for (int k = 0; k < T; k++) hw[j][k] = 0;
         end
         mcnt = 0;
      end else if (v) begin
         for (int j = T - 1; j > 0; j--) begin
            hx[j] = hx[j-1];
            for (int k = 0; k < T; k++)
               hw[j][k] = hw[j-1][k];
         end
         hx[0] = int'(xi);
         for (int k = 0; k < T; k++)
            hw[0][k] = cv ? mc[T-1-k] : mc[k];
         if (mcnt < T) mcnt++;
         ev = (mcnt == T);
      end
      if (we && a < 2'(T)) mc[a] = int'(d);
      e = {ev, model_y()};
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         chk({tag, "_sb_empty"}, 1, 0);
      end else begin
         e = sb_q.pop_front();
         chk({tag, "_y"}, 32'(y), 32'(e[15:0]));
         chk({tag, "_v"}, 32'(y_valid), 32'(e[16]));
      end
   endtask

   task automatic smp(input logic [7:0] xi,
                      input logic cv, input string tag);
      step(1'b1, xi, 1'b0, cv, 1'b0, 2'd0, 8'd0, tag);
   endtask

   task automatic idle(input string tag);
      step(1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, tag);
   endtask

   task automatic wr(input logic [1:0] a,
                     input logic [7:0] d, input string tag);
      step(1'b0, 8'd0, 1'b0, 1'b0, 1'b1, a, d, tag);
   endtask

   task automatic fl(input string tag);
      step(1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0, tag);
   endtask

   initial begin
      model_reset();
      #12;
      chk("rst_y", 32'(y), 0);
      chk("rst_v", 32'(y_valid), 0);
      @(negedge clk);
      rst = 1'b0;

      // correlation with defaults: 4, 11, 20, 29
      smp(8'd1, 1'b0, "c1");
      smp(8'd2, 1'b0, "c2");
      smp(8'd3, 1'b0, "c3");
      smp(8'd4, 1'b0, "c4");
      chk("c4_val", 32'(y), 29);
      fl("f0");

      // convolution: 16 on third sample, no pulse when idle
      smp(8'd1, 1'b1, "v1");
      smp(8'd2, 1'b1, "v2");
      smp(8'd3, 1'b1, "v3");
      chk("v3_val", 32'(y), 16);
      idle("v_idle");
      fl("f1");

      // stall holds y through the gap
      smp(8'd1, 1'b0, "s1");
      smp(8'd2, 1'b0, "s2");
      idle("s_g1");
      idle("s_g2");
      smp(8'd3, 1'b0, "s3");
      chk("s3_val", 32'(y), 20);
      fl("f2");

      // coefficient writes, out-of-range ignored
      wr(2'd2, 8'd10, "w2");
      wr(2'd3, 8'd99, "w3");
      smp(8'd1, 1'b0, "k1");
      smp(8'd1, 1'b0, "k2");
      smp(8'd1, 1'b0, "k3");
      chk("k3_val", 32'(y), 15);
      // write alongside a sample: old weight used on that edge
      step(1'b1, 8'd1, 1'b0, 1'b0, 1'b1, 2'd2, 8'd1,
           "k4");
      chk("k4_val", 32'(y), 15);
      smp(8'd1, 1'b0, "k5");
      chk("k5_val", 32'(y), 6);
      fl("f3");

      // overflow wraps modulo 2^16
      wr(2'd0, 8'd255, "o0");
      wr(2'd1, 8'd255, "o1");
      wr(2'd2, 8'd255, "o2");
      smp(8'd255, 1'b0, "o_s1");
      smp(8'd255, 1'b0, "o_s2");
      smp(8'd255, 1'b0, "o_s3");
      chk("o_val", 32'(y), 64003);

      // flush after two samples restarts priming
      smp(8'd9, 1'b0, "p1");
      smp(8'd7, 1'b0, "p2");
      // flush with a sample present: sample dropped
      step(1'b1, 8'd5, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0,
           "pf");
      wr(2'd0, 8'd2, "r0");
      wr(2'd1, 8'd3, "r1");
      wr(2'd2, 8'd4, "r2");
      smp(8'd1, 1'b0, "q1");
      smp(8'd2, 1'b0, "q2");
      smp(8'd3, 1'b0, "q3");
      chk("q3_val", 32'(y), 20);

      // async reset between edges, with nondefault coefs
      wr(2'd1, 8'd50, "r_pre");
      smp(8'd6, 1'b0, "r_s");
      @(negedge clk);
      x_valid = 1'b0; coef_we = 1'b0;
      #1 rst = 1'b1;
      #1;
      chk("arst_y", 32'(y), 0);
      chk("arst_v", 32'(y_valid), 0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      smp(8'd1, 1'b0, "a1");
      smp(8'd2, 1'b0, "a2");
      smp(8'd3, 1'b0, "a3");
      chk("a3_val", 32'(y), 20);

      chk("sb_drain", 32'(sb_q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
